// File: rtl/dp_dmi_pkg.sv
// Shared types and encodings for the DMI transaction controller.
// Op, status and state encodings follow the RISC-V debug transport module.
package dp_dmi_pkg;

  localparam int DMI_ABITS = 7;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  localparam logic [1:0] STAT_OK     = 2'd0;
  localparam logic [1:0] STAT_FAILED = 2'd2;
  localparam logic [1:0] STAT_BUSY   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } dmi_state_e;

  typedef struct packed {
    logic [DMI_ABITS-1:0] addr;
    logic [31:0]          data;
    logic [1:0]           op;
  } dmi_req_t;

  function automatic logic is_access(input logic [1:0] op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction

endpackage

// File: rtl/dp_dmi_timer.sv
// Watchdog counter for one outstanding DMI phase; LIMIT of 0 disables it.
// expired flags the cycle in which the count reaches LIMIT.
module dp_dmi_timer
  import dp_dmi_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
  localparam logic [W-1:0] LAST = (LIMIT > 0) ? W'(LIMIT - 1) : '0;

  logic [W-1:0] count_r;

  // Phase cycle counter; clear wins over enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (LIMIT > 0) && en && !clr && (count_r == LAST);

endmodule

// File: rtl/dp_dmi_ctrl.sv
// DMI transaction sequencer: scan update -> valid/ready request -> response,
// with DTM busy/sticky-error status and the capture value for the next scan.
module dp_dmi_ctrl
  import dp_dmi_pkg::*;
#(
  parameter int ABITS     = 7,
  parameter int TIMEOUT   = 255,
  parameter int IDLE_HINT = 1
) (
  input  logic             iclk,
  input  logic             iresetn,
  input  logic             dmi_upd,
  input  logic             dmi_cap,
  input  logic [ABITS+33:0] dmi_pdo,
  input  logic             dmireset,
  input  logic             dmihardreset,
  output logic [ABITS+33:0] dmi_pdi,
  output logic [1:0]       dmistat,
  output logic [2:0]       idle,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [ABITS-1:0] req_addr,
  output logic [31:0]      req_data,
  output logic [1:0]       req_op,
  input  logic             rsp_valid,
  output logic             rsp_ready,
  input  logic [31:0]      rsp_data,
  input  logic [1:0]       rsp_op
);

  dmi_state_e       state_r;
  logic [31:0]      rdata_r;
  logic [1:0]       stat_base_s;
  logic [1:0]       stat_next_s;
  logic             tmr_clr_s;
  logic             tmr_en_s;
  logic             tmo_s;
  logic [ABITS-1:0] pdo_addr_s;
  logic [31:0]      pdo_data_s;
  logic [1:0]       pdo_op_s;

  assign pdo_addr_s = dmi_pdo[ABITS+33:34];
  assign pdo_data_s = dmi_pdo[33:2];
  assign pdo_op_s   = dmi_pdo[1:0];
  assign idle       = 3'(IDLE_HINT);

  // Timer restarts on every phase entry and whenever a phase completes
  always_comb begin
    tmr_en_s = (state_r != ST_IDLE);
    case (state_r)
      ST_IDLE: tmr_clr_s = 1'b1;
      ST_REQ:  tmr_clr_s = req_ready;
      ST_RSP:  tmr_clr_s = rsp_valid;
      default: tmr_clr_s = 1'b1;
    endcase
  end

  dp_dmi_timer #(.LIMIT(TIMEOUT)) u_timer (
    .clk     (iclk),
    .rst_n   (iresetn),
    .clr     (tmr_clr_s | dmihardreset),
    .en      (tmr_en_s),
    .expired (tmo_s)
  );

  // Sticky status: dmireset clears first, then the first error to occur sticks
  always_comb begin
    stat_base_s = dmireset ? STAT_OK : dmistat;
    if (stat_base_s != STAT_OK) begin
      stat_next_s = stat_base_s;
    end else if ((dmi_upd || dmi_cap) && (state_r != ST_IDLE)) begin
      stat_next_s = STAT_BUSY;
    end else if (tmo_s || ((state_r == ST_RSP) && rsp_valid && (rsp_op == STAT_FAILED))) begin
      stat_next_s = STAT_FAILED;
    end else begin
      stat_next_s = STAT_OK;
    end
  end

  // Transaction FSM with registered handshake outputs and capture register
  always_ff @(posedge iclk or negedge iresetn) begin
    if (!iresetn) begin
      state_r   <= ST_IDLE;
      req_valid <= 1'b0;
      rsp_ready <= 1'b0;
      req_addr  <= '0;
      req_data  <= 32'd0;
      req_op    <= OP_NOP;
      rdata_r   <= 32'd0;
      dmistat   <= STAT_OK;
      dmi_pdi   <= '0;
    end else if (dmihardreset) begin
      state_r   <= ST_IDLE;
      req_valid <= 1'b0;
      rsp_ready <= 1'b0;
      dmistat   <= STAT_OK;
    end else begin
      dmistat <= stat_next_s;
      if (dmi_cap) begin
        dmi_pdi <= {req_addr, rdata_r, (state_r == ST_IDLE) ? dmistat : STAT_BUSY};
      end
      case (state_r)
        ST_IDLE: begin
          if (dmi_upd && (stat_base_s == STAT_OK) && is_access(pdo_op_s)) begin
            req_addr  <= pdo_addr_s;
            req_data  <= pdo_data_s;
            req_op    <= pdo_op_s;
            req_valid <= 1'b1;
            state_r   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (tmo_s) begin
            req_valid <= 1'b0;
            state_r   <= ST_IDLE;
          end else if (req_ready) begin
            req_valid <= 1'b0;
            rsp_ready <= 1'b1;
            state_r   <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (rsp_valid) begin
            if (req_op == OP_READ) begin
              rdata_r <= rsp_data;
            end
            rsp_ready <= 1'b0;
            state_r   <= ST_IDLE;
          end else if (tmo_s) begin
            rsp_ready <= 1'b0;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          req_valid <= 1'b0;
          rsp_ready <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dp_dmi_ctrl.sv
// Directed bench for dp_dmi_ctrl (ABITS=7, TIMEOUT=8): write/read round trips,
// busy and failure stickiness, timeout, hard reset and async reset.
module tb_dp_dmi_ctrl;
  import dp_dmi_pkg::*;

  logic        iclk = 1'b0;
  logic        iresetn = 1'b0;
  logic        dmi_upd = 1'b0;
  logic        dmi_cap = 1'b0;
  logic [40:0] dmi_pdo = '0;
  logic        dmireset = 1'b0;
  logic        dmihardreset = 1'b0;
  logic [40:0] dmi_pdi;
  logic [1:0]  dmistat;
  logic [2:0]  idle;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [6:0]  req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_op;
  logic        rsp_valid = 1'b0;
  logic        rsp_ready;
  logic [31:0] rsp_data = 32'd0;
  logic [1:0]  rsp_op = 2'd0;

  int       checks = 0;
  int       errors = 0;
  dmi_req_t vec;

  dp_dmi_ctrl #(.ABITS(7), .TIMEOUT(8), .IDLE_HINT(1)) dut (
    .iclk(iclk), .iresetn(iresetn), .dmi_upd(dmi_upd), .dmi_cap(dmi_cap),
    .dmi_pdo(dmi_pdo), .dmireset(dmireset), .dmihardreset(dmihardreset),
    .dmi_pdi(dmi_pdi), .dmistat(dmistat), .idle(idle),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_data(req_data), .req_op(req_op), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_op(rsp_op)
  );

  always #5 iclk = ~iclk;

  always @(posedge iclk) begin
    assert (!(dmi_upd && dmi_cap)) else $error("FAIL upd_cap_overlap");
  end

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic upd(input logic [6:0] a, input logic [31:0] d, input logic [1:0] o);
    vec.addr = a;
    vec.data = d;
    vec.op   = o;
    dmi_pdo  = vec;
    dmi_upd  = 1'b1;
    tick();
    dmi_upd  = 1'b0;
  endtask

  task automatic cap();
    dmi_cap = 1'b1;
    tick();
    dmi_cap = 1'b0;
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst_req_valid", req_valid, 1'b0);
    chk("rst_rsp_ready", rsp_ready, 1'b0);
    chk("rst_dmistat", dmistat, 2'd0);
    chk("rst_dmi_pdi", dmi_pdi, 41'd0);
    chk("rst_req_addr", req_addr, 7'd0);
    chk("rst_idle", idle, 3'd1);
    iresetn = 1'b1;
    tick();

    // Write 0x10 <- DEADBEEF, minimum round trip
    req_ready = 1'b1;
    rsp_valid = 1'b1;
    rsp_data  = 32'hAAAA0000;
    upd(7'h10, 32'hDEADBEEF, 2'd2);
    chk("wr_req_valid", req_valid, 1'b1);
    chk("wr_req_addr", req_addr, 7'h10);
    chk("wr_req_data", req_data, 32'hDEADBEEF);
    chk("wr_req_op", req_op, 2'd2);
    tick();
    chk("wr_accept_valid", req_valid, 1'b0);
    chk("wr_rsp_ready", rsp_ready, 1'b1);
    tick();
    chk("wr_done_rsp_ready", rsp_ready, 1'b0);
    rsp_valid = 1'b0;
    cap();
    chk("wr_capture", dmi_pdi, {7'h10, 32'h00000000, 2'd0});

    // Read 0x11 with a 5-cycle response delay
    upd(7'h11, 32'h0, 2'd1);
    chk("rd_req_valid", req_valid, 1'b1);
    chk("rd_req_op", req_op, 2'd1);
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rd_wait_rsp_ready", rsp_ready, 1'b1);
    end
    rsp_valid = 1'b1;
    rsp_data  = 32'h12345678;
    rsp_op    = 2'd0;
    tick();
    rsp_valid = 1'b0;
    chk("rd_done_rsp_ready", rsp_ready, 1'b0);
    cap();
    chk("rd_capture", dmi_pdi, {7'h11, 32'h12345678, 2'd0});

    // Busy: second update while in RSP
    upd(7'h20, 32'h00000055, 2'd2);
    tick();
    chk("busy_in_rsp", rsp_ready, 1'b1);
    upd(7'h21, 32'h0, 2'd1);
    chk("busy_dmistat", dmistat, 2'd3);
    chk("busy_addr_kept", req_addr, 7'h20);
    chk("busy_op_kept", req_op, 2'd2);
    cap();
    chk("busy_capture", dmi_pdi, {7'h20, 32'h12345678, 2'd3});
    rsp_valid = 1'b1;
    rsp_data  = 32'hCAFEF00D;
    tick();
    rsp_valid = 1'b0;
    chk("busy_first_done", rsp_ready, 1'b0);
    chk("busy_sticky", dmistat, 2'd3);
    upd(7'h22, 32'h0, 2'd1);
    chk("busy_drop_upd", req_valid, 1'b0);
    tick();
    chk("busy_drop_upd2", req_valid, 1'b0);
    dmireset = 1'b1;
    tick();
    dmireset = 1'b0;
    chk("dmireset_clear", dmistat, 2'd0);
    upd(7'h22, 32'h0, 2'd1);
    chk("after_reset_req_valid", req_valid, 1'b1);
    chk("after_reset_req_addr", req_addr, 7'h22);

    // Failed read response
    tick();
    rsp_valid = 1'b1;
    rsp_data  = 32'h0BADC0DE;
    rsp_op    = 2'd2;
    tick();
    rsp_valid = 1'b0;
    rsp_op    = 2'd0;
    chk("fail_dmistat", dmistat, 2'd2);
    cap();
    chk("fail_capture", dmi_pdi, {7'h22, 32'h0BADC0DE, 2'd2});
    upd(7'h23, 32'h1, 2'd2);
    chk("fail_drop_upd", req_valid, 1'b0);

    // dmireset together with an update: clear first, then issue
    vec.addr = 7'h30;
    vec.data = 32'h1;
    vec.op   = 2'd2;
    dmi_pdo  = vec;
    dmireset = 1'b1;
    dmi_upd  = 1'b1;
    tick();
    dmireset = 1'b0;
    dmi_upd  = 1'b0;
    chk("rst_upd_dmistat", dmistat, 2'd0);
    chk("rst_upd_req_valid", req_valid, 1'b1);
    chk("rst_upd_req_addr", req_addr, 7'h30);
    tick();
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    chk("rst_upd_done", rsp_ready, 1'b0);

    // Timeout with req_ready stuck low
    req_ready = 1'b0;
    upd(7'h40, 32'h0, 2'd1);
    chk("tmo_rise", req_valid, 1'b1);
    for (int i = 0; i < 7; i++) tick();
    chk("tmo_still_valid", req_valid, 1'b1);
    chk("tmo_no_err_yet", dmistat, 2'd0);
    tick();
    chk("tmo_drop_valid", req_valid, 1'b0);
    chk("tmo_rsp_ready", rsp_ready, 1'b0);
    chk("tmo_dmistat", dmistat, 2'd2);
    dmireset = 1'b1;
    tick();
    dmireset = 1'b0;

    // dmihardreset during REQ clears busy and aborts
    upd(7'h50, 32'h0, 2'd2);
    chk("hr_req_valid", req_valid, 1'b1);
    upd(7'h5F, 32'h0, 2'd2);
    chk("hr_busy", dmistat, 2'd3);
    dmihardreset = 1'b1;
    tick();
    dmihardreset = 1'b0;
    chk("hr_req_valid_low", req_valid, 1'b0);
    chk("hr_rsp_ready_low", rsp_ready, 1'b0);
    chk("hr_dmistat", dmistat, 2'd0);

    // Async reset in the middle of RSP
    req_ready = 1'b1;
    upd(7'h51, 32'h0, 2'd2);
    tick();
    chk("ar_in_rsp", rsp_ready, 1'b1);
    #2;
    iresetn = 1'b0;
    #1;
    chk("ar_rsp_ready", rsp_ready, 1'b0);
    chk("ar_req_valid", req_valid, 1'b0);
    chk("ar_dmistat", dmistat, 2'd0);
    tick();
    iresetn = 1'b1;
    tick();

    // Fresh write after resets
    upd(7'h52, 32'h00000077, 2'd2);
    chk("post_req_valid", req_valid, 1'b1);
    chk("post_req_addr", req_addr, 7'h52);
    chk("post_req_data", req_data, 32'h00000077);
    tick();
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    chk("post_done", rsp_ready, 1'b0);
    cap();
    chk("post_capture", dmi_pdi, {7'h52, 32'h00000000, 2'd0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
